// File: rtl/dmem_arbiter_if.sv
// Two requester ports plus the single-port data memory pins, as seen by the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, we0, gnt0, rvalid0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, gnt1, rvalid1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd, mem_rd;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_we, mem_a, mem_wd
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded hold sharing one single-port data memory
// between two requesters; load data returns registered one cycle after grant.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input logic            clk,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int NP = 2;

  logic                      last, prev_gnt;
  logic [HW-1:0]             hold_cnt;
  logic [NP-1:0]             req, we, gnt, rvalid;
  logic [NP-1:0][ADDR_W-1:0] addr;
  logic [NP-1:0][DATA_W-1:0] wdata, rdata;
  logic                      any, win;

  assign req   = {bus.req1, bus.req0};
  assign we    = {bus.we1, bus.we0};
  assign addr  = {bus.addr1, bus.addr0};
  assign wdata = {bus.wdata1, bus.wdata0};

  // Gating with reset makes grants and memory strobes drop the instant reset asserts.
  always_comb begin
    any = reset & (|req);
    win = req[1];
    if (&req)
      win = (prev_gnt && hold_cnt < HW'(MAX_HOLD)) ? last : ~last;
    gnt = '0;
    if (any) gnt[win] = 1'b1;
  end

  assign bus.gnt0   = gnt[0];
  assign bus.gnt1   = gnt[1];
  assign bus.mem_we = any & we[win];
  assign bus.mem_a  = any ? addr[win]  : '0;
  assign bus.mem_wd = any ? wdata[win] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last     <= 1'b1;
      prev_gnt <= 1'b0;
      hold_cnt <= '0;
    end else if (any) begin
      if (prev_gnt && win == last)
        hold_cnt <= (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + HW'(1);
      else
        hold_cnt <= HW'(1);
      last     <= win;
      prev_gnt <= 1'b1;
    end else begin
      prev_gnt <= 1'b0;
      hold_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      for (int k = 0; k < NP; k++) begin
        rvalid[k] <= gnt[k] & ~we[k];
        if (gnt[k] & ~we[k]) rdata[k] <= bus.mem_rd;
      end
    end
  end

  assign bus.rvalid0 = rvalid[0];
  assign bus.rvalid1 = rvalid[1];
  assign bus.rdata0  = rdata[0];
  assign bus.rdata1  = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random stimulus against a cycle-level reference of the arbitration rules.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MH = 4;

  logic clk, reset;
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  assign bus.mem_rd = mem[bus.mem_a[5:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[5:2]] <= bus.mem_wd;

  initial begin clk = 0; forever #5 clk = ~clk; end

  int ncmp = 0, nerr = 0;
  int m_last, m_prev, m_streak, run_len, run_port, obs_port;
  bit e_rv [2];
  logic [DW-1:0] e_rd [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic model_reset();
    e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
    m_last = 1; m_prev = 0; m_streak = 0; run_len = 0; run_port = -1;
  endtask

  task automatic zero_checks();
    chk("rst_gnt0", bus.gnt0, 0);     chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_mem_we", bus.mem_we, 0); chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_wd", bus.mem_wd, 0);
    chk("rst_rvalid0", bus.rvalid0, 0); chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_rdata0", bus.rdata0, 0);   chk("rst_rdata1", bus.rdata1, 0);
  endtask

  task automatic do_reset();
    reset = 0; #1;
    zero_checks();
    model_reset();
    @(posedge clk); #1 reset = 1;
  endtask

  // One clock: check combinational and registered outputs mid-cycle, then
  // either let the edge happen or assert reset before it.
  task automatic step(input bit rst_mid);
    bit r [2], w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    int g;
    @(negedge clk);
    r[0] = bus.req0; w[0] = bus.we0; a[0] = bus.addr0; d[0] = bus.wdata0;
    r[1] = bus.req1; w[1] = bus.we1; a[1] = bus.addr1; d[1] = bus.wdata1;
    if (r[0] && r[1]) g = (m_prev && m_streak < MH) ? m_last : 1 - m_last;
    else if (r[0]) g = 0;
    else if (r[1]) g = 1;
    else g = -1;
    chk("gnt0", bus.gnt0, g == 0);
    chk("gnt1", bus.gnt1, g == 1);
    chk("mem_we", bus.mem_we, g >= 0 ? w[g] : 1'b0);
    chk("mem_a", bus.mem_a, g >= 0 ? a[g] : '0);
    chk("mem_wd", bus.mem_wd, g >= 0 ? d[g] : '0);
    chk("rvalid0", bus.rvalid0, e_rv[0]);
    chk("rvalid1", bus.rvalid1, e_rv[1]);
    chk("rdata0", bus.rdata0, e_rd[0]);
    chk("rdata1", bus.rdata1, e_rd[1]);
    obs_port = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
    if (r[0] && r[1] && obs_port >= 0) begin
      run_len  = (obs_port == run_port) ? run_len + 1 : 1;
      run_port = obs_port;
      chk("hold_run_le_max", run_len <= MH, 1);
    end else begin
      run_len = 0; run_port = -1;
    end
    if (rst_mid) begin
      reset = 0; #1;
      zero_checks();
      model_reset();
      @(posedge clk); #1;
      chk("rst_edge_rvalid0", bus.rvalid0, 0);
      chk("rst_edge_rvalid1", bus.rvalid1, 0);
      reset = 1;
      return;
    end
    e_rv[0] = 0; e_rv[1] = 0;
    if (g >= 0) begin
      if (w[g]) ref_mem[a[g][5:2]] = d[g];
      else begin e_rv[g] = 1; e_rd[g] = ref_mem[a[g][5:2]]; end
      m_streak = (m_prev && g == m_last) ? m_streak + 1 : 1;
      m_last = g; m_prev = 1;
    end else begin
      m_prev = 0; m_streak = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    model_reset();
    reset = 1; #1;
    do_reset();

    // Idle after release
    for (int i = 0; i < 5; i++) step(0);

    // Port 0 store then load
    drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, '0, '0); step(0);
    drive(1, 0, 32'h10, 32'h0, 0, 0, '0, '0);        step(0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);                step(0);
    chk("st_ld_rdata0", bus.rdata0, 32'hDEADBEEF);

    // First tie after reset goes to port 0, then hold pattern 0000 1111 0000 1111
    do_reset();
    drive(1, 0, 32'h4, '0, 1, 0, 32'h8, '0);
    for (int i = 0; i < 16; i++) begin
      step(0);
      chk("hold_seq", obs_port, (i / 4) % 2);
    end

    // Lone requester is never limited; contention then goes to the other port
    do_reset();
    drive(0, 0, '0, '0, 1, 0, 32'hC, '0);
    for (int i = 0; i < 10; i++) begin
      step(0);
      chk("solo_gnt1", obs_port, 1);
    end
    drive(1, 0, 32'h14, '0, 1, 0, 32'hC, '0); step(0);
    chk("after_solo_gnt0", obs_port, 0);

    // Reset during a port 1 load, then during a port 1 store
    do_reset();
    drive(0, 0, '0, '0, 1, 0, 32'h18, '0); step(1);
    chk("mid_load_rdata1", bus.rdata1, 0);
    drive(0, 0, '0, '0, 1, 1, 32'h20, 32'h12345678); step(1);
    drive(0, 0, '0, '0, 1, 0, 32'h20, '0); step(0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);     step(0);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom, $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom, $urandom);
      step($urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
